// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared encodings and widths for the two-port RAM arbiter
// and the wait-state sequencers that reuse its down-counter.
package ram_arbiter_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int CTR_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ACCESS  = 2'd1,
        ARB_ACK     = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } arb_owner_t;

    // One requester's access as presented to the RAM port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              byte_op;
        logic              wr;
    } arb_req_t;

    // A requester is pending while either strobe is held.
    function automatic logic req_pending(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/ram_arbiter_wait_ctr.sv
// arb_wait_ctr: loadable down-counter with a zero flag. Load wins over
// decrement; decrement stops at zero so the flag stays asserted.
module arb_wait_ctr
    import ram_arbiter_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Count register: load, decrement toward zero, or hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between the CPU bus path and a DMA master.
// DMA has fixed priority; each access holds the RAM strobe for WAIT_STATES+1
// cycles, then gives the owner a one-cycle ack and waits for its request to
// drop before arbitrating again.
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive DMA grants
// taken while the CPU was pending, the next contested arbitration goes to the CPU.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_byte_op,
    output logic              cpu_ack,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              dma_rd,
    input  logic              dma_wr,
    input  logic              dma_byte_op,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_out,
    input  logic [DATA_W-1:0] ram_data_in,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic              ram_byte_op,
    output logic [1:0]        owner
);

    if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait_states
        $error("ram_arbiter: WAIT_STATES must be within 0..15");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("ram_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    arb_owner_t own_r;
    arb_req_t   cpu_req_s;
    arb_req_t   dma_req_s;
    arb_req_t   sel_req_s;
    logic       cpu_pend_s;
    logic       dma_pend_s;
    logic       own_pend_s;
    logic       grant_cpu_s;
    logic       grant_dma_s;
    logic       grant_any_s;
    logic       ctr_dec_s;
    logic       ctr_zero_s;
    logic       done_s;
    logic       release_s;
    logic       starve_hit_s;

    assign cpu_pend_s = req_pending(cpu_rd, cpu_wr);
    assign dma_pend_s = req_pending(dma_rd, dma_wr);

    // A request with both strobes high is a write; rd is simply not carried.
    assign cpu_req_s = '{addr: cpu_addr, wdata: cpu_wdata, byte_op: cpu_byte_op, wr: cpu_wr};
    assign dma_req_s = '{addr: dma_addr, wdata: dma_wdata, byte_op: dma_byte_op, wr: dma_wr};
    assign sel_req_s = grant_dma_s ? dma_req_s : cpu_req_s;

    assign grant_any_s = grant_cpu_s | grant_dma_s;
    assign owner       = own_r;

    arb_wait_ctr #(
        .W (CTR_W)
    ) u_wait_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (grant_any_s),
        .load_val (CTR_W'(WAIT_STATES)),
        .dec      (ctr_dec_s),
        .zero     (ctr_zero_s)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_r;

    // Count DMA wins over a waiting CPU; any CPU grant or idle CPU clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_r <= '0;
        end else if (grant_cpu_s || !cpu_pend_s) begin
            starve_r <= '0;
        end else if (grant_dma_s && (starve_r < STARVE_W'(STARVE_LIMIT))) begin
            starve_r <= starve_r + STARVE_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    assign starve_hit_s = (starve_r >= STARVE_W'(STARVE_LIMIT));
`else
    assign starve_hit_s = 1'b0;
`endif

    // Is the current owner still holding its request?
    always_comb begin
        own_pend_s = 1'b0;
        case (own_r)
            OWN_CPU: own_pend_s = cpu_pend_s;
            OWN_DMA: own_pend_s = dma_pend_s;
            default: own_pend_s = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (grant_any_s) begin
                    state_nxt_s = ARB_ACCESS;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                if (ctr_zero_s) begin
                    state_nxt_s = ARB_ACK;
                end else begin
                    state_nxt_s = ARB_ACCESS;
                end
            end
            ARB_ACK: begin
                state_nxt_s = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                if (own_pend_s) begin
                    state_nxt_s = ARB_RELEASE;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // FSM output decode: grants in IDLE, wait counting, completion, release.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dma_s = 1'b0;
        ctr_dec_s   = 1'b0;
        done_s      = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (dma_pend_s && !(cpu_pend_s && starve_hit_s)) begin
                    grant_dma_s = 1'b1;
                end else if (cpu_pend_s) begin
                    grant_cpu_s = 1'b1;
                end else begin
                    grant_cpu_s = 1'b0;
                end
            end
            ARB_ACCESS: begin
                if (ctr_zero_s) begin
                    done_s = 1'b1;
                end else begin
                    ctr_dec_s = 1'b1;
                end
            end
            ARB_ACK: begin
                done_s = 1'b0;
            end
            ARB_RELEASE: begin
                release_s = !own_pend_s;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // RAM port and owner: latch the winner at grant, drop strobes when done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr     <= '0;
            ram_data_out <= '0;
            ram_byte_op  <= 1'b0;
            ram_rd       <= 1'b0;
            ram_wr       <= 1'b0;
            own_r        <= OWN_NONE;
        end else if (grant_any_s) begin
            ram_addr     <= sel_req_s.addr;
            ram_data_out <= sel_req_s.wdata;
            ram_byte_op  <= sel_req_s.byte_op;
            ram_rd       <= ~sel_req_s.wr;
            ram_wr       <= sel_req_s.wr;
            own_r        <= grant_dma_s ? OWN_DMA : OWN_CPU;
        end else if (done_s) begin
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;
        end else if (release_s) begin
            own_r <= OWN_NONE;
        end else begin
            own_r <= own_r;
        end
    end

    // Per-port ack pulse and read-data capture at completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            cpu_ack <= done_s && (own_r == OWN_CPU);
            dma_ack <= done_s && (own_r == OWN_DMA);
            if (done_s && ram_rd && (own_r == OWN_CPU)) begin
                cpu_rdata <= ram_data_in;
            end
            if (done_s && ram_rd && (own_r == OWN_DMA)) begin
                dma_rdata <= ram_data_in;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors against ram_arbiter with a transaction-level
// model (grant time + fixed latency) compared every cycle, plus literal checks.
module tb_ram_arbiter;

    localparam int WS    = 1;
    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [21:0] cpu_addr = '0, dma_addr = '0;
    logic [15:0] cpu_wdata = '0, dma_wdata = '0;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_byte_op = 1'b0;
    logic        dma_rd = 1'b0, dma_wr = 1'b0, dma_byte_op = 1'b0;
    logic        cpu_ack, dma_ack;
    logic [21:0] ram_addr;
    logic [15:0] ram_data_out, ram_data_in;
    logic        ram_rd, ram_wr, ram_byte_op;
    logic [1:0]  owner;

    int vectors = 0;
    int miscompares = 0;
    int cpu_ack_cnt = 0, dma_ack_cnt = 0, rd_cyc = 0, wr_cyc = 0;

    always #5 clk = ~clk;

    // RAM contents: one known word, everything else derived from the address.
    function automatic logic [15:0] ram_fn(input logic [21:0] a);
        if (a == 22'o001000) return 16'o012737;
        return a[15:0] ^ 16'h5a5a;
    endfunction

    assign ram_data_in = ram_fn(ram_addr);

    ram_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byte_op(cpu_byte_op), .cpu_ack(cpu_ack),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
        .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_byte_op(dma_byte_op), .dma_ack(dma_ack),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_byte_op(ram_byte_op), .owner(owner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A grant at edge g means: strobe for edges g..g+WS, ack after edge g+WS+1,
    // release possible from edge g+WS+3 once the owner's request is low.
    bit          m_busy = 1'b0, m_wr = 1'b0, m_bop = 1'b0;
    int          m_who = 0, m_g = 0, m_k = 0, m_starve = 0;
    logic [21:0] m_addr = '0;
    logic [15:0] m_wdata = '0, m_cpu_rdata = '0, m_dma_rdata = '0;
    bit          e_cpu_ack = 1'b0, e_dma_ack = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
    logic [1:0]  e_owner = 2'b00;

    initial begin : model
        bit cp, dp, take_dma;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_busy = 1'b0; m_wr = 1'b0; m_bop = 1'b0; m_who = 0; m_g = 0; m_k = 0;
                m_starve = 0; m_addr = '0; m_wdata = '0; m_cpu_rdata = '0; m_dma_rdata = '0;
                e_cpu_ack = 1'b0; e_dma_ack = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_owner = 2'b00;
            end else begin
                cp = cpu_rd | cpu_wr;
                dp = dma_rd | dma_wr;
                e_cpu_ack = 1'b0;
                e_dma_ack = 1'b0;
                if (!m_busy) begin
                    if (cp || dp) begin
                        take_dma = dp && !(cp && GUARD && (m_starve >= LIMIT));
                        m_busy = 1'b1;
                        m_g = m_k;
                        if (take_dma) begin
                            m_who = 2; m_wr = dma_wr; m_addr = dma_addr;
                            m_wdata = dma_wdata; m_bop = dma_byte_op;
                            if (cp) m_starve++;
                        end else begin
                            m_who = 1; m_wr = cpu_wr; m_addr = cpu_addr;
                            m_wdata = cpu_wdata; m_bop = cpu_byte_op;
                            m_starve = 0;
                        end
                    end
                end else if (m_k == m_g + WS + 1) begin
                    if (m_who == 1) begin
                        e_cpu_ack = 1'b1;
                        if (!m_wr) m_cpu_rdata = ram_fn(m_addr);
                    end else begin
                        e_dma_ack = 1'b1;
                        if (!m_wr) m_dma_rdata = ram_fn(m_addr);
                    end
                end else if (m_k >= m_g + WS + 3) begin
                    if ((m_who == 1) ? !cp : !dp) m_busy = 1'b0;
                end
                if (!cp) m_starve = 0;
                e_rd = m_busy && !m_wr && ((m_k - m_g) <= WS);
                e_wr = m_busy && m_wr && ((m_k - m_g) <= WS);
                e_owner = m_busy ? 2'(m_who) : 2'b00;
                m_k++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(posedge clk); #2;
            check("owner", 32'(owner), 32'(e_owner));
            check("ram_rd", 32'(ram_rd), 32'(e_rd));
            check("ram_wr", 32'(ram_wr), 32'(e_wr));
            check("cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
            check("dma_ack", 32'(dma_ack), 32'(e_dma_ack));
            check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
            check("dma_rdata", 32'(dma_rdata), 32'(m_dma_rdata));
            check("ram_addr", 32'(ram_addr), 32'(m_addr));
            check("ram_byte_op", 32'(ram_byte_op), 32'(m_bop));
            check("ram_data_out", 32'(ram_data_out), 32'(m_wdata));
            if (cpu_ack === 1'b1) cpu_ack_cnt++;
            if (dma_ack === 1'b1) dma_ack_cnt++;
            if (ram_rd === 1'b1) rd_cyc++;
            if (ram_wr === 1'b1) wr_cyc++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time=%0t required=<200000", $time);
        $fatal(1, "watchdog expired");
    end

    // Stimulus-side sample point, one time unit after the compare process.
    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic wait_ack(input bit is_dma, input int budget, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        while (!ok && (cyc < budget)) begin
            tick();
            cyc++;
            if ((is_dma ? dma_ack : cpu_ack) === 1'b1) ok = 1'b1;
        end
    endtask

    // ---------------- directed vectors ----------------
    initial begin : stim
        bit ok, got;
        int cyc, c0, d0, r0, w0, dma_before;

        repeat (3) @(posedge clk);
        #3;
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_ram_rd", 32'(ram_rd), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // CPU read of a known word
        @(negedge clk) begin cpu_addr = 22'o001000; cpu_rd = 1'b1; end
        tick();
        check("t1_c1_ram_rd", 32'(ram_rd), 32'd1);
        check("t1_c1_owner", 32'(owner), 32'd1);
        check("t1_c1_ram_addr", 32'(ram_addr), 32'o001000);
        tick();
        check("t1_c2_ram_rd", 32'(ram_rd), 32'd1);
        check("t1_c2_cpu_ack", 32'(cpu_ack), 32'd0);
        tick();
        check("t1_c3_ram_rd", 32'(ram_rd), 32'd0);
        check("t1_c3_cpu_ack", 32'(cpu_ack), 32'd1);
        check("t1_c3_rdata", 32'(cpu_rdata), 32'o012737);
        check("t1_c3_owner", 32'(owner), 32'd1);
        @(negedge clk) cpu_rd = 1'b0;
        tick();
        check("t1_c4_cpu_ack", 32'(cpu_ack), 32'd0);
        tick();
        check("t1_c5_owner", 32'(owner), 32'd0);
        tick();

        // DMA byte write
        c0 = cpu_ack_cnt; d0 = dma_ack_cnt; w0 = wr_cyc;
        @(negedge clk) begin
            dma_addr = 22'o000201; dma_wdata = 16'o000177; dma_byte_op = 1'b1; dma_wr = 1'b1;
        end
        wait_ack(1'b1, 10, ok, cyc);
        check("t2_dma_ack_seen", 32'(ok), 32'd1);
        check("t2_latency", 32'(cyc), 32'd3);
        check("t2_ram_byte_op", 32'(ram_byte_op), 32'd1);
        check("t2_ram_addr", 32'(ram_addr), 32'o000201);
        check("t2_ram_data_out", 32'(ram_data_out), 32'o000177);
        @(negedge clk) begin dma_wr = 1'b0; dma_byte_op = 1'b0; end
        repeat (3) tick();
        check("t2_wr_cycles", 32'(wr_cyc - w0), 32'd2);
        check("t2_dma_acks", 32'(dma_ack_cnt - d0), 32'd1);
        check("t2_cpu_acks", 32'(cpu_ack_cnt - c0), 32'd0);

        // Simultaneous CPU read and DMA write; DMA holds its request 3 extra cycles
        c0 = cpu_ack_cnt; d0 = dma_ack_cnt;
        @(negedge clk) begin
            cpu_addr = 22'o002000; cpu_rd = 1'b1;
            dma_addr = 22'o003000; dma_wdata = 16'o123456; dma_wr = 1'b1;
        end
        wait_ack(1'b1, 10, ok, cyc);
        check("t3_dma_first", 32'(ok), 32'd1);
        check("t3_cpu_not_yet", 32'(cpu_ack_cnt - c0), 32'd0);
        repeat (3) tick();
        check("t3_owner_held", 32'(owner), 32'd2);
        @(negedge clk) dma_wr = 1'b0;
        wait_ack(1'b0, 10, ok, cyc);
        check("t3_cpu_ack_seen", 32'(ok), 32'd1);
        check("t3_cpu_latency", 32'(cyc), 32'd4);
        check("t3_cpu_rdata", 32'(cpu_rdata), 32'h5e5a);
        check("t3_dma_acks", 32'(dma_ack_cnt - d0), 32'd1);
        @(negedge clk) cpu_rd = 1'b0;
        repeat (3) tick();

        // Reset during the first ACCESS cycle
        @(negedge clk) begin cpu_addr = 22'o001000; cpu_rd = 1'b1; end
        tick();
        check("t4_ram_rd_before", 32'(ram_rd), 32'd1);
        c0 = cpu_ack_cnt;
        @(negedge clk) begin reset_n = 1'b0; cpu_rd = 1'b0; end
        #1;
        check("t4_ram_rd_drop", 32'(ram_rd), 32'd0);
        check("t4_owner_drop", 32'(owner), 32'd0);
        repeat (3) tick();
        check("t4_no_ack", 32'(cpu_ack_cnt - c0), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) cpu_rd = 1'b1;
        wait_ack(1'b0, 10, ok, cyc);
        check("t4_fresh_ack", 32'(ok), 32'd1);
        check("t4_fresh_latency", 32'(cyc), 32'd3);
        check("t4_fresh_rdata", 32'(cpu_rdata), 32'o012737);
        @(negedge clk) cpu_rd = 1'b0;
        repeat (3) tick();

        // CPU rd and wr together: a single write
        c0 = cpu_ack_cnt; r0 = rd_cyc; w0 = wr_cyc;
        @(negedge clk) begin
            cpu_addr = 22'o004000; cpu_wdata = 16'o055555; cpu_rd = 1'b1; cpu_wr = 1'b1;
        end
        wait_ack(1'b0, 10, ok, cyc);
        check("t5_ack_seen", 32'(ok), 32'd1);
        @(negedge clk) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
        repeat (3) tick();
        check("t5_rd_cycles", 32'(rd_cyc - r0), 32'd0);
        check("t5_wr_cycles", 32'(wr_cyc - w0), 32'd2);
        check("t5_cpu_acks", 32'(cpu_ack_cnt - c0), 32'd1);
        check("t5_data_out", 32'(ram_data_out), 32'o055555);
        check("t5_rdata_kept", 32'(cpu_rdata), 32'o012737);

        // DMA re-requests continuously while the CPU read is held
        c0 = cpu_ack_cnt; dma_before = 0; got = 1'b0;
        @(negedge clk) begin
            cpu_addr = 22'o001000; cpu_rd = 1'b1; dma_addr = 22'o005000; dma_rd = 1'b1;
        end
        fork
            begin : dma_side
                for (int r = 0; r < 6; r++) begin
                    wait_ack(1'b1, 30, ok, cyc);
                    check("t6_dma_ack_seen", 32'(ok), 32'd1);
                    if (cpu_ack_cnt == c0) dma_before++;
                    @(negedge clk) dma_rd = 1'b0;
                    @(negedge clk);
                    @(negedge clk) dma_rd = (r < 5);
                end
                check("t6_cpu_acks_in_window", 32'(cpu_ack_cnt - c0), GUARD ? 32'd1 : 32'd0);
                check("t6_dma_grants_before_cpu", 32'(dma_before), GUARD ? 32'd4 : 32'd6);
            end
            begin : cpu_side
                for (int i = 0; (i < 120) && !got; i++) begin
                    tick();
                    if (cpu_ack === 1'b1) got = 1'b1;
                end
                check("t6_cpu_eventually_served", 32'(got), 32'd1);
                @(negedge clk) cpu_rd = 1'b0;
            end
        join
        repeat (4) tick();
        check("t6_final_owner", 32'(owner), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
